instruction_fetch_unit: RTL

- Writer side of the instruction register: owns the program counter (PC) and fetches 16-bit instruction words from instruction memory.
- Presents each fetched word on instruction and pulses regWrite for one cycle; the instruction register latches it on the following CLK falling edge.
- Handles branch redirect, stall, memory-latency waits and a fetch-timeout fault.
- Sits between instruction memory and the instruction register / control unit.

---
 rtl/instruction_fetch_unit_pkg.sv | 16 +
 rtl/instruction_fetch_unit_if.sv | 33 +++
 rtl/instruction_fetch_unit_timeout.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings and
// instruction word width.
package instruction_fetch_unit_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      FS_IDLE      = 3'd0,
      FS_FETCH     = 3'd1,
      FS_ISSUE     = 3'd2,
      FS_WAIT_EXEC = 3'd3,
      FS_REDIRECT  = 3'd4,
      FS_FAULT     = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: control-unit handshake, instruction memory port and the
// instruction register write port, bundled for a single master (the fetch unit).
interface instruction_fetch_unit_if
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 16
);
   logic                fetchEn;
   logic                stall;
   logic                nextInstr;
   logic                branchTaken;
   logic [ADDR_W-1:0]   branchTarget;
   logic [ADDR_W-1:0]   memAddr;
   logic                memReq;
   logic                memValid;
   logic [INSTR_W-1:0]  memData;
   logic [INSTR_W-1:0]  instruction;
   logic                regWrite;
   logic [ADDR_W-1:0]   pcOut;
   logic                fetchErr;

   modport master (
      input  fetchEn, stall, nextInstr, branchTaken, branchTarget,
      input  memValid, memData,
      output memAddr, memReq, instruction, regWrite, pcOut, fetchErr
   );

   modport slave (
      output fetchEn, stall, nextInstr, branchTaken, branchTarget,
      output memValid, memData,
      input  memAddr, memReq, instruction, regWrite, pcOut, fetchErr
   );
endinterface

// File: rtl/instruction_fetch_unit_timeout.sv
// Fetch timeout counter: counts cycles spent waiting for memory and flags
// expiry on the TIMEOUT-th enabled cycle.
module fetch_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic CLK,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   logic [7:0] count;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)       count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 8'd1;
   end

   assign expire = enable && (count == 8'(TIMEOUT - 1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests words from instruction memory
// and strobes each fetched word into the instruction register.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic                      CLK,
   input  logic                      reset,
   instruction_fetch_unit_if.master  bus
);
   fetch_state_e        state, state_n;
   logic [ADDR_W-1:0]   pc, pc_n, mem_addr, mem_addr_n, pc_out, pc_out_n;
   logic [INSTR_W-1:0]  instr, instr_n;
   logic                mem_req, mem_req_n, reg_write, reg_write_n;
   logic                fetch_err, fetch_err_n, pending, pending_n;
   logic                redirect, expire, cnt_clear;

   // A branch is honoured everywhere except the terminal fault state.
   assign redirect  = bus.branchTaken && (state != FS_FAULT);
   assign cnt_clear = redirect || (state != FS_FETCH);

   fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK    (CLK),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (state == FS_FETCH),
      .expire (expire)
   );

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state     <= FS_IDLE;
         pc        <= RESET_PC;
         mem_addr  <= RESET_PC;
         pc_out    <= RESET_PC;
         mem_req   <= 1'b0;
         instr     <= '0;
         reg_write <= 1'b0;
         fetch_err <= 1'b0;
         pending   <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         mem_addr  <= mem_addr_n;
         pc_out    <= pc_out_n;
         mem_req   <= mem_req_n;
         instr     <= instr_n;
         reg_write <= reg_write_n;
         fetch_err <= fetch_err_n;
         pending   <= pending_n;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves a signal unassigned and infers a latch.
      state_n     = state;
      pc_n        = pc;
      mem_addr_n  = mem_addr;
      pc_out_n    = pc_out;
      mem_req_n   = mem_req;
      instr_n     = instr;
      reg_write_n = 1'b0;
      fetch_err_n = fetch_err;
      pending_n   = pending;

      if (redirect) begin
         // Any same-cycle memValid is dropped; REDIRECT keeps memReq low a cycle.
         pc_n      = bus.branchTarget;
         pending_n = 1'b0;
         mem_req_n = 1'b0;
         state_n   = FS_REDIRECT;
      end else begin
         unique case (state)
            FS_IDLE, FS_REDIRECT: begin
               state_n = FS_IDLE;
               if (bus.fetchEn && !bus.stall) begin
                  state_n    = FS_FETCH;
                  mem_addr_n = pc;
                  mem_req_n  = 1'b1;
                  pending_n  = 1'b0;
               end
            end
            FS_FETCH: begin
               if (expire) begin
                  mem_req_n   = 1'b0;
                  fetch_err_n = 1'b1;
                  state_n     = FS_FAULT;
               end else if (bus.memValid) begin
                  instr_n     = bus.memData;
                  pc_out_n    = pc;
                  pc_n        = pc + 1'b1;
                  reg_write_n = 1'b1;
                  mem_req_n   = 1'b0;
                  state_n     = FS_ISSUE;
               end
            end
            FS_ISSUE: state_n = FS_WAIT_EXEC;
            FS_WAIT_EXEC: begin
               if (!bus.fetchEn) begin
                  pending_n = pending || bus.nextInstr;
                  state_n   = FS_IDLE;
               end else if (bus.nextInstr || pending) begin
                  if (bus.stall) begin
                     pending_n = 1'b1;
                  end else begin
                     state_n    = FS_FETCH;
                     mem_addr_n = pc;
                     mem_req_n  = 1'b1;
                     pending_n  = 1'b0;
                  end
               end
            end
            FS_FAULT: mem_req_n = 1'b0;
            default:  state_n = FS_FAULT;
         endcase
      end
   end

   assign bus.memAddr     = mem_addr;
   assign bus.memReq      = mem_req;
   assign bus.instruction = instr;
   assign bus.regWrite    = reg_write;
   assign bus.pcOut       = pc_out;
   assign bus.fetchErr    = fetch_err;
endmodule
